// File: rtl/ibtb_update_queue.sv
// In-order update FIFO feeding the ibtb write port; drains one entry per cycle unless held or flushed.
// Optional build macro IBTB_UPDATE_COALESCE_EN merges a repeat of the newest entry's (pc, gh) in place.
package corep;
  typedef logic [37:0] pc38_t;
  typedef logic [7:0]  ibtb_gh_t;
  typedef logic [31:0] ibtb_info_t;
endpackage

module ibtb_update_queue #(
  parameter int DEPTH = 4,
  parameter int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              enq_valid,
  output logic              enq_ready,
  input  corep::pc38_t      enq_src_pc38,
  input  corep::ibtb_gh_t   enq_ibtb_gh,
  input  corep::ibtb_info_t enq_tgt_ibtb_info,
  input  logic              hold,
  input  logic              flush,
  output logic              update_valid,
  output corep::pc38_t      update_src_pc38,
  output corep::ibtb_gh_t   update_ibtb_gh,
  output corep::ibtb_info_t update_tgt_ibtb_info,
  output logic [OCC_W-1:0]  occupancy
);
  localparam int PTR_W = $clog2(DEPTH);

  corep::pc38_t      pc_q   [DEPTH];
  corep::ibtb_gh_t   gh_q   [DEPTH];
  corep::ibtb_info_t info_q [DEPTH];

  logic [PTR_W-1:0] head, tail, newest;
  logic [OCC_W-1:0] count;
  logic             full, deq, enq_fire, alloc, coal_hit;

  assign newest = tail - PTR_W'(1);
  assign full   = (count == OCC_W'(DEPTH));

`ifdef IBTB_UPDATE_COALESCE_EN
  // The newest entry can only be leaving when it is also the head.
  assign coal_hit = (count != '0) &&
                    (enq_src_pc38 == pc_q[newest]) &&
                    (enq_ibtb_gh == gh_q[newest]) &&
                    !(deq && (head == newest));
`else
  assign coal_hit = 1'b0;
`endif

  assign enq_ready = !full || coal_hit;
  assign enq_fire  = enq_valid && enq_ready && !flush;
  assign alloc     = enq_fire && !coal_hit;
  assign deq       = (count != '0) && !hold && !flush;

  assign update_valid         = deq;
  assign update_src_pc38      = pc_q[head];
  assign update_ibtb_gh       = gh_q[head];
  assign update_tgt_ibtb_info = info_q[head];
  assign occupancy            = count;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= '0;
        gh_q[i]   <= '0;
        info_q[i] <= '0;
      end
    end else begin
      if (flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (alloc) tail <= tail + PTR_W'(1);
        if (deq)   head <= head + PTR_W'(1);
        unique case ({alloc, deq})
          2'b10:   count <= count + OCC_W'(1);
          2'b01:   count <= count - OCC_W'(1);
          default: count <= count;
        endcase
      end
      if (alloc) begin
        pc_q[tail]   <= enq_src_pc38;
        gh_q[tail]   <= enq_ibtb_gh;
        info_q[tail] <= enq_tgt_ibtb_info;
      end
      if (enq_fire && coal_hit) info_q[newest] <= enq_tgt_ibtb_info;
    end
  end
endmodule

// File: doc/ibtb_update_queue.md
Name: ibtb_update_queue

Overview:
- Producer side of the ibtb update port. Accepts resolved indirect-branch outcomes from the backend branch-resolution path and buffers them in an in-order FIFO.
- Drains at most one entry per cycle onto the ibtb update interface (update_valid / update_src_pc38 / update_ibtb_gh / update_tgt_ibtb_info).
- Sits between the branch unit and ibtb, so the backend never stalls on ibtb write timing.

Parameters:
- DEPTH, 4: FIFO entries; power of 2, at least 2.
- OCC_W, $clog2(DEPTH+1): occupancy width.

Ports:
- CLK  input  1  clock
- nRST  input  1  async active-low reset
- enq_valid  input  1  resolved indirect branch presented
- enq_ready  output  1  queue can accept enq this cycle
- enq_src_pc38  input  corep::pc38_t (38)  branch source PC
- enq_ibtb_gh  input  corep::ibtb_gh_t  global history at prediction
- enq_tgt_ibtb_info  input  corep::ibtb_info_t  resolved target info
- hold  input  1  suppress drain this cycle (ibtb busy)
- flush  input  1  discard all pending entries
- update_valid  output  1  ibtb update strobe
- update_src_pc38  output  corep::pc38_t  head source PC
- update_ibtb_gh  output  corep::ibtb_gh_t  head history
- update_tgt_ibtb_info  output  corep::ibtb_info_t  head target info
- occupancy  output  OCC_W  valid entries held

Behaviour:
- Clock and reset: one clock (CLK). Reset nRST is asynchronous, active-low.
- Storage:
  - DEPTH-entry flop array.
  - head/tail pointers of $clog2(DEPTH) bits, wrapping modulo DEPTH.
  - count register of OCC_W bits.
- Reset values:
  - head = tail = count = 0; entry storage = 0.
  - Therefore update_valid=0, update_* fields=0, occupancy=0, enq_ready=1.
- Enqueue:
  - Fires when enq_valid & enq_ready & ~flush.
  - Writes entry[tail]; tail += 1; count += 1.
  - enq_ready = (count != DEPTH). enq_ready does not depend on a same-cycle dequeue; a full queue refuses even if draining.
- Drain:
  - update_valid = (count != 0) & ~hold & ~flush.
  - update_* fields are driven directly from entry[head], flop-sourced and stable while not dequeued.
  - When update_valid is high: head += 1; count -= 1. ibtb always accepts, so there is no ready.
- Latency: an entry enqueued in cycle N is visible on update_* at cycle N+1 at earliest, when the queue is empty and not held.
- Simultaneous enq and deq: count unchanged, both pointers advance. Legal at any count 1..DEPTH-1.
- Empty:
  - update_valid = 0; update_* show stale entry[head] and must be ignored.
  - An enq at empty does not bypass to the output the same cycle.
- Full: enq_ready = 0; any enq_valid is ignored with no state change.
- Wrap-around: pointers wrap DEPTH-1 -> 0; ordering is strictly FIFO across the wrap.
- Hold: freezes head and count, and gates update_valid. Enqueue still accepted.
- Flush:
  - Next cycle head = tail = count = 0.
  - Same-cycle enqueue is dropped; same-cycle update_valid is forced 0.
  - Entry storage is not cleared.
- Async reset mid-operation returns everything to reset values immediately; pending entries are lost.
- occupancy = count (registered).

Optional Feature:
- Macro: IBTB_UPDATE_COALESCE_EN.
- Defined:
  - If count != 0 and enq_src_pc38 and enq_ibtb_gh equal the newest entry (entry[tail-1]), and that entry is not being dequeued this cycle, the enqueue overwrites that entry's tgt_ibtb_info.
  - A coalesced enqueue does not move tail or count.
  - enq_ready = (count != DEPTH) | coalesce_hit, so a matching enq is accepted even when full.
  - The newest-entry match applies across the pointer wrap.
- Undefined: no compare logic. Every accepted enq allocates, and behaviour is exactly as above.

Test Plan:
- Reset, then one enq of pc=0x12_3456_789A, gh=0x5, info=I0 with hold=0 -> cycle+1: update_valid=1 with those values; cycle+2: update_valid=0, occupancy=0.
- hold=1, 5 back-to-back enqs A..E with DEPTH=4 -> A..D accepted, enq_ready=0 when E is presented, E ignored, occupancy=4. Release hold -> A,B,C,D drained in order on 4 consecutive cycles.
- Wrap: 6 enqs interleaved with a drain every cycle, starting at count=2 -> outputs strictly in enq order across the head 3->0 wrap; occupancy stays 2.
- Flush at count=3 with a simultaneous enq -> update_valid=0 that cycle; next cycle occupancy=0 and no update issued from the flushed or dropped entries.
- Full, one dequeue plus enq same cycle -> enq refused (enq_ready=0); occupancy 4->3.
- With IBTB_UPDATE_COALESCE_EN and hold=1: enq (pc P, gh G, I1) then (P, G, I2) -> occupancy=1. Release -> a single update with info I2. Without the macro: two updates, I1 then I2.
